// File: rtl/attention_pkg.sv
// rtl/attention_pkg.sv - shared FP32 constants, FSM state type and ordering helpers for the row-max block
package attention_pkg;

    localparam logic [31:0] FP32_NINF = 32'hFF800000;
    localparam logic [31:0] FP32_QNAN = 32'h7FC00000;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    function automatic logic fp32_is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Maps sign-magnitude FP32 onto an unsigned key; both zeros share one key so they compare equal.
    function automatic logic [31:0] fp32_order_key(input logic [31:0] x);
        if (x[30:0] == 31'd0)
            return 32'h80000000;
        else if (x[31])
            return ~x;
        else
            return {1'b1, x[30:0]};
    endfunction

endpackage

// File: rtl/fp32_max2.sv
// rtl/fp32_max2.sv - combinational FP32 max of two scores; ties keep a, NaN reported separately
module fp32_max2
    import attention_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] max_val,
    output logic        any_nan
);

    logic b_greater;

    assign b_greater = fp32_order_key(b) > fp32_order_key(a);
    assign max_val   = b_greater ? b : a;
    assign any_nan   = fp32_is_nan(a) | fp32_is_nan(b);

endmodule

// File: rtl/attention_row_max.sv
// rtl/attention_row_max.sv - buffers one row of masked scores, then replays each with the row max
module attention_row_max
    import attention_pkg::*;
#(
    parameter int T      = 4,
    parameter int DATA_W = 32,
    parameter int T_W    = (T <= 1) ? 1 : $clog2(T)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [T_W-1:0]    in_q,
    input  logic [T_W-1:0]    in_k,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] out_max,
    output logic [T_W-1:0]    out_q,
    output logic [T_W-1:0]    out_k,
    output logic              out_last,
    output logic              out_all_masked,
    output logic              err
);

    state_t              state;
    logic [T_W-1:0]      cnt;
    logic [T_W-1:0]      idx;
    logic [T_W-1:0]      row_q;
    logic [DATA_W-1:0]   run_max;
    logic                nan_seen;
    logic                all_masked;
    logic [DATA_W-1:0]   row_buf [T];

    logic                accept;
    logic                drain_hs;
    logic [DATA_W-1:0]   cmp_max;
    logic                cmp_nan;

    assign accept   = in_valid && (state == FILL);
    assign drain_hs = out_ready && (state == DRAIN);

    fp32_max2 u_fp32_max2 (
        .a       (run_max),
        .b       (in_data),
        .max_val (cmp_max),
        .any_nan (cmp_nan)
    );

    // rst_n is active-high in this codebase despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state      <= FILL;
            cnt        <= '0;
            idx        <= '0;
            row_q      <= '0;
            run_max    <= '0;
            nan_seen   <= 1'b0;
            all_masked <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        if ((in_k != cnt) || ((cnt != '0) && (in_q != row_q)))
                            err <= 1'b1;
                        if (cnt == '0) begin
                            row_q      <= in_q;
                            run_max    <= in_data;
                            nan_seen   <= fp32_is_nan(in_data);
                            all_masked <= (in_data == FP32_NINF);
                        end else begin
                            run_max    <= cmp_max;
                            nan_seen   <= nan_seen | cmp_nan;
                            all_masked <= all_masked & (in_data == FP32_NINF);
                        end
                        if (cnt == T_W'(T - 1)) begin
                            cnt   <= '0;
                            state <= DRAIN;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_hs) begin
                        if (idx == T_W'(T - 1)) begin
                            idx   <= '0;
                            state <= FILL;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            row_buf[cnt] <= in_data;
    end

    // Outputs are forced to zero outside DRAIN so reset and idle never expose stale buffer contents.
    assign in_ready       = (state == FILL);
    assign out_valid      = (state == DRAIN);
    assign out_data       = out_valid ? row_buf[idx] : '0;
    assign out_max        = !out_valid ? '0 : (nan_seen ? FP32_QNAN : run_max);
    assign out_q          = out_valid ? row_q : '0;
    assign out_k          = out_valid ? idx : '0;
    assign out_last       = out_valid && (idx == T_W'(T - 1));
    assign out_all_masked = out_valid && all_masked;

endmodule

// File: tb/tb_attention_row_max.sv
// tb/tb_attention_row_max.sv - directed self-checking bench for attention_row_max
module tb_attention_row_max;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_q;
    logic [1:0]  in_k;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [31:0] out_max;
    logic [1:0]  out_q;
    logic [1:0]  out_k;
    logic        out_last;
    logic        out_all_masked;
    logic        err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    attention_row_max #(.T(4), .DATA_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_q           (in_q),
        .in_k           (in_k),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_max        (out_max),
        .out_q          (out_q),
        .out_k          (out_k),
        .out_last       (out_last),
        .out_all_masked (out_all_masked),
        .err            (err)
    );

    function automatic logic [70:0] beat_of(input logic v, input logic [31:0] d, input logic [31:0] m,
                                            input logic [1:0] q, input logic [1:0] k,
                                            input logic l, input logic am);
        return {v, d, m, q, k, l, am};
    endfunction

    // d holds score k at bits [32k +: 32]; ks holds the in_k sent for sample i at bits [2i +: 2]
    task automatic feed_row(input logic [1:0] q0, input logic [1:0] q_alt, input int alt_at,
                            input logic [127:0] d, input logic [7:0] ks);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL feed_ready i=%0d got=%b want=1", i, in_ready);
            end
            in_valid = 1'b1;
            in_q     = (i == alt_at) ? q_alt : q0;
            in_k     = ks[2*i +: 2];
            in_data  = d[32*i +: 32];
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Expects to be entered on the first DRAIN negedge; leaves at the first FILL negedge.
    task automatic drain_row(input string name, input logic [127:0] d, input logic [31:0] m,
                             input logic [1:0] q, input logic am, input bit toggle);
        logic [70:0] got, exp;
        for (int k = 0; k < 4; k++) begin
            exp = beat_of(1'b1, d[32*k +: 32], m, q, 2'(k), k == 3, am);
            if (toggle) begin
                out_ready = 1'b0;
                in_valid  = 1'b1;
                in_data   = 32'h12345678;
                in_k      = 2'd0;
                #1;
                got = {out_valid, out_data, out_max, out_q, out_k, out_last, out_all_masked};
                total++;
                if (got !== exp || in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL %s_hold k=%0d got=%h rdy=%b want=%h rdy=0", name, k, got, in_ready, exp);
                end
                @(negedge clk);
            end
            out_ready = 1'b1;
            #1;
            got = {out_valid, out_data, out_max, out_q, out_k, out_last, out_all_masked};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL %s k=%0d got=%h want=%h", name, k, got, exp);
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_back_to_fill got v=%b r=%b want v=0 r=1", name, out_valid, in_ready);
        end
    endtask

    task automatic check_err(input string name, input logic want);
        total++;
        if (err !== want) begin
            bad++;
            $display("FAIL %s_err got=%b want=%b", name, err, want);
        end
    endtask

    task automatic test_reset();
        logic [70:0] got;
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_q = '0; in_k = '0;
        repeat (3) @(negedge clk);
        got = {out_valid, out_data, out_max, out_q, out_k, out_last, out_all_masked};
        total++;
        if (got !== 71'd0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%h err=%b want=0", got, err);
        end
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got r=%b v=%b want r=1 v=0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        logic [127:0] d = {32'h3F000000, 32'hBF800000, 32'h40000000, 32'h3F800000};
        feed_row(2'd1, 2'd1, -1, d, 8'b11_10_01_00);
        drain_row("basic", d, 32'h40000000, 2'd1, 1'b0, 1'b0);
        check_err("basic", 1'b0);
    endtask

    task automatic test_masked();
        logic [127:0] d = {32'hFF800000, 32'hFF800000, 32'hFF800000, 32'h3F800000};
        logic [127:0] m = {4{32'hFF800000}};
        feed_row(2'd0, 2'd0, -1, d, 8'b11_10_01_00);
        drain_row("causal", d, 32'h3F800000, 2'd0, 1'b0, 1'b0);
        feed_row(2'd3, 2'd3, -1, m, 8'b11_10_01_00);
        drain_row("all_masked", m, 32'hFF800000, 2'd3, 1'b1, 1'b0);
    endtask

    task automatic test_nan_zero();
        logic [127:0] n = {32'hBF800000, 32'h7FC00001, 32'h40000000, 32'h3F800000};
        logic [127:0] z = {32'h80000000, 32'h80000000, 32'h80000000, 32'h00000000};
        logic [127:0] g = {32'hC0400000, 32'hBF000000, 32'hC0000000, 32'hBF800000};
        feed_row(2'd2, 2'd2, -1, n, 8'b11_10_01_00);
        drain_row("nan", n, 32'h7FC00000, 2'd2, 1'b0, 1'b0);
        feed_row(2'd1, 2'd1, -1, z, 8'b11_10_01_00);
        drain_row("zero_tie", z, 32'h00000000, 2'd1, 1'b0, 1'b0);
        feed_row(2'd0, 2'd0, -1, g, 8'b11_10_01_00);
        drain_row("negatives", g, 32'hBF000000, 2'd0, 1'b0, 1'b0);
        check_err("nan_zero", 1'b0);
    endtask

    task automatic test_backpressure();
        logic [127:0] d = {32'h41200000, 32'h40400000, 32'hC1000000, 32'h40A00000};
        feed_row(2'd3, 2'd3, -1, d, 8'b11_10_01_00);
        drain_row("toggle", d, 32'h41200000, 2'd3, 1'b0, 1'b1);
        check_err("toggle", 1'b0);
    endtask

    task automatic test_err();
        logic [127:0] d = {32'h3F000000, 32'hBF800000, 32'h40000000, 32'h3F800000};
        feed_row(2'd1, 2'd1, -1, d, 8'b11_01_10_00);
        check_err("order", 1'b1);
        drain_row("order", d, 32'h40000000, 2'd1, 1'b0, 1'b0);
        feed_row(2'd2, 2'd3, 2, d, 8'b11_10_01_00);
        drain_row("q_change", d, 32'h40000000, 2'd2, 1'b0, 1'b0);
        check_err("sticky", 1'b1);
    endtask

    task automatic test_reset_mid();
        logic [70:0]  got;
        logic [127:0] d = {32'h3E800000, 32'h3F400000, 32'h3F000000, 32'h3E000000};
        @(negedge clk);
        in_valid = 1'b1; in_q = 2'd2; in_k = 2'd0; in_data = 32'h7F000000;
        @(negedge clk);
        in_k = 2'd1; in_data = 32'h7F000000;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        got = {out_valid, out_data, out_max, out_q, out_k, out_last, out_all_masked};
        total++;
        if (got !== 71'd0 || err !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset got=%h err=%b want=0", got, err);
        end
        @(negedge clk);
        rst_n = 1'b0;
        feed_row(2'd0, 2'd0, -1, d, 8'b11_10_01_00);
        drain_row("after_reset", d, 32'h3F400000, 2'd0, 1'b0, 1'b0);
        check_err("after_reset", 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_masked();
        test_nan_zero();
        test_backpressure();
        test_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
